mac_matvec_sequencer: RTL and testbench
=======================================

// Module: mac_matvec_sequencer
// PURPOSE
//   Feeds the signed 8-bit MAC unit: computes y[i] = sum_k A[i][k]*x[k] for a ROWS x COLS matrix.
//   A and x are read from 1-cycle-latency synchronous RAMs; each row's 19-bit MAC result goes to a result RAM.
//   Owns the MAC: drives mac_clear and mac_a/mac_b, samples mac_out. Sits between the operand memories and the MAC.
// PARAMETERS
//   ROWS    8   matrix rows = number of results
//   COLS    8   matrix columns = products per dot product
//   A_AW    6   A address width, >= clog2(ROWS*COLS)
//   X_AW    3   x address width, >= clog2(COLS)
//   R_AW    3   result address width, >= clog2(ROWS)
// PORTS
//   clk        in   1     rising-edge clock
//   reset_n    in   1     synchronous active-low reset
//   start      in   1     begin full mat-vec; sampled in IDLE only
//   busy       out  1     high in RUN/DRAIN/WRITE
//   done       out  1     1-cycle pulse after last result written
//   a_addr     out  A_AW  A RAM address, row-major (i*COLS+k)
//   a_rdata    in   8     A element, signed, valid cycle after a_addr
//   x_addr     out  X_AW  x RAM address (k)
//   x_rdata    in   8     x element, signed, valid cycle after x_addr
//   mac_clear  out  1     MAC accumulator clear
//   mac_a      out  8     MAC operand A, signed
//   mac_b      out  8     MAC operand B, signed
//   mac_out    in   19    MAC accumulator, signed
//   res_we     out  1     result RAM write strobe
//   res_addr   out  R_AW  result index i
//   res_wdata  out  19    signed result y[i]
// BEHAVIOUR
//   MAC contract: each edge, acc <= mac_clear ? 0 : acc + mac_a*mac_b; mac_out is acc.
//   Reset (reset_n=0 at edge): state IDLE; all outputs 0; row/col counters 0; the edge never writes.
//   Reset mid-run abandons the operation, issues no further write, and does not pulse done.
//   States: IDLE -> RUN on start. RUN has COLS cycles, issuing a_addr/x_addr for k=0..COLS-1.
//   RUN -> DRAIN after k=COLS-1. DRAIN -> WRITE. WRITE -> RUN (row+1), or DONE if row=ROWS-1. DONE -> IDLE.
//   mac_clear=1 only in the RUN cycle with k=0; acc is 0 before the first product arrives.
//   Operand pipe: a registered valid bit follows address issue by 1 cycle.
//   mac_a/mac_b = valid_d ? a_rdata/x_rdata : 0; they are forced to 0 when not valid, so MAC idles at +0.
//   Product k accumulates on the edge ending cycle issue+1. The last product is in mac_out during WRITE.
//   WRITE: res_we=1 for exactly 1 cycle, res_addr=row, res_wdata=mac_out (combinational pass).
//   Per row: COLS+2 cycles. Total latency: start edge -> done high = ROWS*(COLS+2)+1 cycles.
//   Arithmetic: all signed; 8-bit operands, 16-bit products, 19-bit sum.
//   The worst case, COLS=8 and every product (-128)*(-128), gives +131072; this fits 19-bit, so no saturation is needed.
//   COLS>8 may overflow; this is out of spec.
//   start while busy or in DONE: ignored, with no restart and no counter change.
//   start held high: one run per IDLE visit; it re-triggers when sampled in IDLE after DONE.
//   Addresses hold their last value outside RUN; memories are read-only to this block.
// TESTING
//   1 A=all 127, x=all 127, start -> 8 writes, res_addr 0..7, each res_wdata=129032; done at cycle 81.
//   2 A=all -128, x=all 127 -> every y=-130048. A=all -128, x=all -128 -> every y=131072 (19'h20000).
//   3 Row i of A = {i,0,..,0}, x[0]=1 -> y[i]=i. Checks row-major addressing and per-row mac_clear.
//   4 Reset pulsed at cycle 25 of a run -> no res_we after reset, no done.
//      A fresh start then gives a correct full result.
//   5 start re-asserted during RUN and in DONE -> ignored; exactly 8 writes, one done pulse.
//   6 10 runs with $random A/x vs a reference model -> all y match; mac_a/mac_b == 0 whenever valid_d=0.

Source files
------------

// File: rtl/mac_matvec_sequencer.sv
// Matrix-vector sequencer: walks A (row-major) and x through a 1-cycle RAM read,
// feeds the external signed MAC and writes one 19-bit dot product per row.
module mac_matvec_sequencer #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    parameter int unsigned A_AW = 6,
    parameter int unsigned X_AW = 3,
    parameter int unsigned R_AW = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [A_AW-1:0] a_addr,
    input  logic [7:0]      a_rdata,
    output logic [X_AW-1:0] x_addr,
    input  logic [7:0]      x_rdata,
    output logic            mac_clear,
    output logic [7:0]      mac_a,
    output logic [7:0]      mac_b,
    input  logic [18:0]     mac_out,
    output logic            res_we,
    output logic [R_AW-1:0] res_addr,
    output logic [18:0]     res_wdata
);

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 19;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [X_AW-1:0] LAST_COL = X_AW'(COLS - 1);
    localparam logic [R_AW-1:0] LAST_ROW = R_AW'(ROWS - 1);

    logic [2:0]      state, state_n;
    logic [R_AW-1:0] row, row_n;
    logic [X_AW-1:0] col, col_n;
    logic [A_AW-1:0] a_addr_n;
    logic [X_AW-1:0] x_addr_n;
    logic [R_AW-1:0] res_addr_n;
    logic            mac_clear_n, res_we_n, done_n, busy_n;
    logic            valid_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            a_addr    <= '0;
            x_addr    <= '0;
            res_addr  <= '0;
            mac_clear <= 1'b0;
            res_we    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            valid_d   <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            col       <= col_n;
            a_addr    <= a_addr_n;
            x_addr    <= x_addr_n;
            res_addr  <= res_addr_n;
            mac_clear <= mac_clear_n;
            res_we    <= res_we_n;
            done      <= done_n;
            busy      <= busy_n;
            valid_d   <= (state == S_RUN);
        end
    end

    // Next state; a_addr simply increments since rows are contiguous in A
    always_comb begin
        state_n     = state;
        row_n       = row;
        col_n       = col;
        a_addr_n    = a_addr;
        x_addr_n    = x_addr;
        res_addr_n  = res_addr;
        mac_clear_n = 1'b0;
        res_we_n    = 1'b0;
        done_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_RUN;
                    row_n       = '0;
                    col_n       = '0;
                    a_addr_n    = '0;
                    x_addr_n    = '0;
                    mac_clear_n = 1'b1;
                end
            end
            S_RUN: begin
                if (col == LAST_COL) begin
                    state_n = S_DRAIN;
                end else begin
                    col_n    = col + X_AW'(1);
                    a_addr_n = a_addr + A_AW'(1);
                    x_addr_n = x_addr + X_AW'(1);
                end
            end
            S_DRAIN: begin
                state_n    = S_WRITE;
                res_we_n   = 1'b1;
                res_addr_n = row;
            end
            S_WRITE: begin
                if (row == LAST_ROW) begin
                    state_n = S_DONE;
                end else begin
                    state_n     = S_RUN;
                    row_n       = row + R_AW'(1);
                    col_n       = '0;
                    a_addr_n    = a_addr + A_AW'(1);
                    x_addr_n    = '0;
                    mac_clear_n = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n == S_RUN) || (state_n == S_DRAIN) || (state_n == S_WRITE);
    end

    // Operands are zeroed outside the valid window so the MAC adds +0
    assign mac_a     = valid_d ? a_rdata : DW'(0);
    assign mac_b     = valid_d ? x_rdata : DW'(0);
    assign res_wdata = res_we ? mac_out : RW'(0);

endmodule

// File: tb/tb_mac_matvec_sequencer.sv
// Bench for mac_matvec_sequencer: RAM and MAC models around the DUT, expected
// results queued at issue and checked by an independent write monitor.
module tb_mac_matvec_sequencer;

    logic        clk, reset_n, start;
    logic        busy, done, mac_clear, res_we;
    logic [5:0]  a_addr;
    logic [2:0]  x_addr, res_addr;
    logic [7:0]  a_rdata, x_rdata, mac_a, mac_b;
    logic [18:0] mac_out, res_wdata;

    logic [7:0]  a_mem [64];
    logic [7:0]  x_mem [8];
    logic signed [18:0] acc = '0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [18:0] data;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    bit   mon_on = 0;

    mac_matvec_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .a_addr(a_addr), .a_rdata(a_rdata), .x_addr(x_addr), .x_rdata(x_rdata),
        .mac_clear(mac_clear), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Synchronous read RAMs and the MAC unit
    always @(posedge clk) begin
        a_rdata <= a_mem[a_addr];
        x_rdata <= x_mem[x_addr];
        acc     <= mac_clear ? 19'sd0 : acc + 19'($signed(mac_a) * $signed(mac_b));
    end
    assign mac_out = acc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes, checks idle operands, counts done pulses
    always @(negedge clk) begin
        if (mon_on) begin
            if (res_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", res_addr, res_wdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_addr", 32'(res_addr), 32'(e.addr));
                    check("res_wdata", 32'(res_wdata), 32'(e.data));
                end
            end
            if (!busy || res_we) begin
                check("mac_a_idle", 32'(mac_a), 32'd0);
                check("mac_b_idle", 32'(mac_b), 32'd0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_const(input int v);
        for (int i = 0; i < 8; i++) exp_q.push_back('{addr: 3'(i), data: 19'(v)});
    endtask

    task automatic push_model();
        for (int i = 0; i < 8; i++) begin
            int s;
            s = 0;
            for (int k = 0; k < 8; k++) begin
                int av, xv;
                av = int'($signed(a_mem[i*8+k]));
                xv = int'($signed(x_mem[k]));
                s += av * xv;
            end
            exp_q.push_back('{addr: 3'(i), data: 19'(s)});
        end
    endtask

    task automatic fill(input logic [7:0] av, input logic [7:0] xv);
        for (int j = 0; j < 64; j++) a_mem[j] = av;
        for (int k = 0; k < 8; k++) x_mem[k] = xv;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_a_addr", 32'(a_addr), 0);
        check("rst_x_addr", 32'(x_addr), 0);
        check("rst_mac_clear", 32'(mac_clear), 0);
        check("rst_mac_a", 32'(mac_a), 0);
        check("rst_mac_b", 32'(mac_b), 0);
        check("rst_res_we", 32'(res_we), 0);
        check("rst_res_addr", 32'(res_addr), 0);
        check("rst_res_wdata", 32'(res_wdata), 0);
    endtask

    // Full run; expectations must be queued by the caller. poke adds stray starts.
    task automatic do_run(input bit poke);
        int lat, w0, d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        lat = 0;
        while (!done && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (poke) start = ((lat >= 5 && lat < 8) || lat == 80);
        end
        start = 0;
        check("done_latency", 32'(lat), 32'd81);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 0);
        repeat (20) @(negedge clk);
        check("idle_after_run", 32'(busy), 0);
        check("writes_per_run", 32'(wr_cnt - w0), 32'd8);
        check("dones_per_run", 32'(done_cnt - d0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        reset_n = 0;
        start   = 0;
        fill(8'd0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset_n = 1;
        mon_on  = 1;

        // all 127: 8*127*127
        fill(8'sd127, 8'sd127);
        push_const(129032);
        do_run(0);

        fill(8'h80, 8'sd127);
        push_const(-130048);
        do_run(0);

        fill(8'h80, 8'h80);
        push_const(131072);
        do_run(0);

        // only column 0 nonzero: y[i] = i
        fill(8'd0, 8'd5);
        x_mem[0] = 8'd1;
        for (int i = 0; i < 8; i++) begin
            a_mem[i*8] = 8'(i);
            exp_q.push_back('{addr: 3'(i), data: 19'(i)});
        end
        do_run(0);

        // reset in the middle of row 2
        begin
            int w0, d0;
            fill(8'd3, 8'd7);
            push_const(168);
            @(negedge clk);
            start = 1;
            @(posedge clk);
            @(negedge clk);
            start = 0;
            repeat (25) @(negedge clk);
            reset_n = 0;
            @(negedge clk);
            exp_q.delete();
            check_reset_outputs();
            reset_n = 1;
            w0 = wr_cnt;
            d0 = done_cnt;
            repeat (100) @(negedge clk);
            check("no_write_after_reset", 32'(wr_cnt - w0), 0);
            check("no_done_after_reset", 32'(done_cnt - d0), 0);
            check("idle_after_reset", 32'(busy), 0);
            check("reset_rows_written", 32'(w0), 32'd34);
        end
        push_const(168);
        do_run(0);

        // stray starts during RUN and in DONE
        fill(8'hFE, 8'd9);
        push_const(-144);
        do_run(1);

        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 64; j++) a_mem[j] = 8'($urandom);
            for (int k = 0; k < 8; k++) x_mem[k] = 8'($urandom);
            push_model();
            do_run(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
